pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_entry.sv | 28 ++
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for the pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 16;
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

  function automatic logic [1:0] stateOccupancy(stateT s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of the pipeline stage register.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              clr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, in_ctrl, flush, clr, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, clr, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_entry.sv
// One data+ctrl holding register; a bubbled load replaces ctrl with CTRL_BUBBLE.
module pipe_entry #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  output logic [DATA_W-1:0] dataQ,
  output logic [CTRL_W-1:0] ctrlQ
);

  always_ff @(negedge clk) begin
    if (reset || clear) begin
      dataQ <= '0;
      ctrlQ <= '0;
    end else if (load) begin
      dataQ <= dataIn;
      ctrlQ <= bubble ? CTRL_BUBBLE : ctrlIn;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush-to-bubble and clear, clocked on the falling edge.
// Optional skid entry (state TWO, registered in_ready) enabled by PIPE_STAGE_SKID_EN.
//
//   state | meaning
//   EMPTY | nothing held, out_valid low
//   ONE   | main entry valid
//   TWO   | main and skid valid, upstream stalled (skid build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  stateT             state, stateNext;
  logic              inReady, outValid, inXfer, outXfer;
  logic              mainLoad, mainBubble;
  logic [DATA_W-1:0] mainDataIn, mainData;
  logic [CTRL_W-1:0] mainCtrlIn, mainCtrl;

  assign outValid = (state != EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  logic              inReadyQ, skidLoad, mainFromSkid;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;

  assign inReady = inReadyQ;
`else
  assign inReady = !outValid || bus.out_ready;
`endif

  assign inXfer  = bus.in_valid && inReady;
  assign outXfer = outValid && bus.out_ready;

  always_comb begin
    stateNext = state;
    mainLoad  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skidLoad     = 1'b0;
    mainFromSkid = 1'b0;
`endif
    if (bus.clr) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            stateNext = ONE;
            mainLoad  = 1'b1;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainLoad = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (inXfer) begin
            stateNext = TWO;
            skidLoad  = 1'b1;
`endif
          end else if (outXfer) begin
            stateNext = EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          // in_ready is low here, so the only event is draining into main.
          if (outXfer) begin
            stateNext    = ONE;
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
`endif
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= stateNext;
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(negedge clk) begin
    if (reset) inReadyQ <= 1'b1;
    else       inReadyQ <= (stateNext != TWO);
  end

  // The skid's ctrl was already bubbled when it was captured.
  assign mainDataIn = mainFromSkid ? skidData : bus.in_data;
  assign mainCtrlIn = mainFromSkid ? skidCtrl : bus.in_ctrl;
  assign mainBubble = bus.flush && !mainFromSkid;

  pipe_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CTRL_BUBBLE(CTRL_BUBBLE)
  ) skid (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clr),
    .load  (skidLoad),
    .bubble(bus.flush),
    .dataIn(bus.in_data),
    .ctrlIn(bus.in_ctrl),
    .dataQ (skidData),
    .ctrlQ (skidCtrl)
  );
`else
  assign mainDataIn = bus.in_data;
  assign mainCtrlIn = bus.in_ctrl;
  assign mainBubble = bus.flush;
`endif

  pipe_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CTRL_BUBBLE(CTRL_BUBBLE)
  ) main (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clr),
    .load  (mainLoad),
    .bubble(mainBubble),
    .dataIn(mainDataIn),
    .ctrlIn(mainCtrlIn),
    .dataQ (mainData),
    .ctrlQ (mainCtrl)
  );

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = mainData;
  assign bus.out_ctrl  = mainCtrl;
  assign bus.occupancy = stateOccupancy(state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: queue-level reference model plus output monitor.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [CW-1:0] BUB = 16'h8001;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entT;

  logic clk = 1'b1;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  bit   chkEn = 1'b0;
  int   modelCnt = 0;
  bit   modelZero = 1'b1;
  entT  sb[$];
  entT  popped;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity CAP; it reads inputs and
  // DUT outputs mid-cycle (rising edge) ahead of the falling update edge.
  always @(posedge clk) begin
    bit expReady, inX, outX;
    if (chkEn) begin
      expReady = (CAP == 2) ? (modelCnt < 2) : (modelCnt == 0 || bus.out_ready);
      check("occupancy", 64'(bus.occupancy), 64'(modelCnt));
      check("out_valid", 64'(bus.out_valid), 64'(modelCnt != 0));
      check("in_ready", 64'(bus.in_ready), 64'(expReady));
      if (modelZero) begin
        check("zero_data", 64'(bus.out_data), 64'd0);
        check("zero_ctrl", 64'(bus.out_ctrl), 64'd0);
      end
      if (reset || bus.clr) begin
        modelCnt  = 0;
        modelZero = 1'b1;
        sb.delete();
      end else begin
        inX  = bus.in_valid && expReady;
        outX = (modelCnt > 0) && bus.out_ready;
        if (inX) begin
          sb.push_back('{d: bus.in_data, c: (bus.flush ? BUB : bus.in_ctrl)});
          modelZero = 1'b0;
        end
        modelCnt = modelCnt + int'(inX) - int'(outX);
      end
    end
  end

  // Monitor: every accepted output must match the oldest outstanding entry.
  always @(posedge clk) begin
    if (chkEn && !reset && !bus.clr && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none at %0t", bus.out_data, $time);
      end else begin
        popped = sb.pop_front();
        check("out_data", 64'(bus.out_data), 64'(popped.d));
        check("out_ctrl", 64'(bus.out_ctrl), 64'(popped.c));
      end
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input bit fl, input bit cl, input bit rdy, input bit rst);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.flush     = fl;
    bus.clr       = cl;
    bus.out_ready = rdy;
    reset         = rst;
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(0, '0, '0, 0, 0, 0, 1);
    cyc(0, '0, '0, 0, 0, 0, 1);
    chkEn = 1'b1;

    // Back-to-back stream with downstream always ready.
    cyc(1, 32'h10, 16'h0001, 0, 0, 1, 0);
    cyc(1, 32'h11, 16'h0002, 0, 0, 1, 0);
    cyc(1, 32'h12, 16'h0003, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);

    // Downstream stalled while two entries arrive, then released.
    cyc(1, 32'hA, 16'h00AA, 0, 0, 0, 0);
    cyc(1, 32'hB, 16'h00BB, 0, 0, 0, 0);
    cyc(1, 32'hC, 16'h00CC, 0, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);

    // Flushed load keeps data but carries the bubble ctrl; lone flush is a no-op.
    cyc(1, 32'h1234, 16'hFFFF, 1, 0, 0, 0);
    cyc(0, 32'h5555, 16'hFFFF, 1, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);

    // Fill, then clear with a competing input on the same edge.
    cyc(1, 32'h21, 16'h0021, 0, 0, 0, 0);
    cyc(1, 32'h22, 16'h0022, 0, 0, 0, 0);
    cyc(1, 32'h23, 16'h0023, 1, 1, 1, 0);
    cyc(1, 32'h24, 16'h0024, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);

    // Reset while full, then stream fresh data.
    cyc(1, 32'h31, 16'h0031, 0, 0, 0, 0);
    cyc(1, 32'h32, 16'h0032, 0, 0, 0, 0);
    cyc(1, 32'h33, 16'h0033, 0, 1, 1, 1);
    cyc(1, 32'h34, 16'h0034, 0, 0, 1, 0);
    cyc(1, 32'h35, 16'h0035, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);

    // Held entry with a stalled consumer and a waiting producer.
    cyc(1, 32'h41, 16'h0041, 0, 0, 0, 0);
    cyc(1, 32'h42, 16'h0042, 0, 0, 0, 0);
    cyc(1, 32'h43, 16'h0043, 0, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);
    cyc(0, '0, '0, 0, 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), $urandom(), CW'($urandom()),
          bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 39) == 0),
          bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 4; i++) cyc(0, '0, '0, 0, 0, 1, 0);
    check("drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
